fg_seq_ctrl: RTL and testbench

//  Waveform sequencer for the function generator core. Holds a DEPTH-entry step table
//  (signal type, count, duty, dwell) and plays it in order, driving the core's
//  sig_type/set_count/duty_cycle inputs. Clamps counts to the core's legal range.

---
 rtl/fg_pkg.sv | 57 +++++
 rtl/fg_seq_ctrl_if.sv | 51 +++++
 rtl/fg_seq_table.sv | 25 ++
 rtl/fg_seq_ctrl.sv | 150 +++++++++++++++
 tb/tb_fg_seq_ctrl.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fg_pkg.sv
// Shared types and limits for the function generator core and its step sequencer.
// Optional sweep support is compiled in when FG_SEQ_SWEEP_EN is defined.
package fg_pkg;

  typedef enum logic [1:0] {
    SINE     = 2'd0,
    TRIANGLE = 2'd1,
    SQUARE   = 2'd2,
    PWM      = 2'd3
  } signal_t;

  localparam logic [31:0] FG_MAX_CNT_TABLE   = 32'd9999;
  localparam logic [31:0] FG_MAX_CNT_DIGITAL = 32'd499999;
  localparam logic [31:0] FG_RST_COUNT       = 32'd999;

  // Stored dwell field is sized for the widest supported DWELL_W (up to 32).
  localparam int FG_DWELL_MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DWELL = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  typedef struct packed {
    signal_t                   sig_type;
    logic [31:0]               set_count;
    logic [7:0]                duty;
    logic [FG_DWELL_MAX_W-1:0] dwell;
`ifdef FG_SEQ_SWEEP_EN
    logic signed [15:0]        delta;
`endif
  } fg_step_t;

  // Table-driven waveforms have a smaller legal period range than the digital ones.
  function automatic logic [31:0] fg_count_limit(input signal_t t);
    return (t == SINE || t == TRIANGLE) ? FG_MAX_CNT_TABLE : FG_MAX_CNT_DIGITAL;
  endfunction

  function automatic logic [31:0] fg_clamp_count(input signal_t t, input logic [31:0] c);
    return (c > fg_count_limit(t)) ? fg_count_limit(t) : c;
  endfunction

  function automatic logic [31:0] fg_sweep_count(input signal_t t, input logic [31:0] c,
                                                 input logic signed [15:0] d);
    logic signed [33:0] sum;
    sum = $signed({2'b00, c}) + 34'(d);
    if (sum < 34'sd1)
      return 32'd1;
    else if (sum > $signed({2'b00, fg_count_limit(t)}))
      return fg_count_limit(t);
    else
      return sum[31:0];
  endfunction

endpackage

// File: rtl/fg_seq_ctrl_if.sv
// Register-side bus of the step sequencer: table writes, commands, status and core config.
// The wr_delta field exists only when FG_SEQ_SWEEP_EN is defined.
interface fg_seq_ctrl_if #(
  parameter int DEPTH   = 8,
  parameter int DWELL_W = 16
);
  import fg_pkg::*;

  localparam int IW = $clog2(DEPTH);

  logic               wr_en;
  logic [IW-1:0]      wr_idx;
  signal_t            wr_sig_type;
  logic [31:0]        wr_set_count;
  logic [7:0]         wr_duty;
  logic [DWELL_W-1:0] wr_dwell;
`ifdef FG_SEQ_SWEEP_EN
  logic signed [15:0] wr_delta;
`endif
  logic [IW:0]        num_steps;
  logic               loop_en;
  logic               start;
  logic               stop;

  logic               busy;
  logic               done;
  logic [IW-1:0]      cur_step;
  signal_t            cfg_sig_type;
  logic [31:0]        cfg_set_count;
  logic [7:0]         cfg_duty_cycle;
  logic               cfg_valid;

  modport master (
    output wr_en, wr_idx, wr_sig_type, wr_set_count, wr_duty, wr_dwell,
`ifdef FG_SEQ_SWEEP_EN
    output wr_delta,
`endif
    output num_steps, loop_en, start, stop,
    input  busy, done, cur_step, cfg_sig_type, cfg_set_count, cfg_duty_cycle, cfg_valid
  );

  modport slave (
    input  wr_en, wr_idx, wr_sig_type, wr_set_count, wr_duty, wr_dwell,
`ifdef FG_SEQ_SWEEP_EN
    input  wr_delta,
`endif
    input  num_steps, loop_en, start, stop,
    output busy, done, cur_step, cfg_sig_type, cfg_set_count, cfg_duty_cycle, cfg_valid
  );

endinterface

// File: rtl/fg_seq_table.sv
// Step table: DEPTH entries of fg_step_t, synchronous write, asynchronous read.
module fg_seq_table
  import fg_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  fg_step_t                 wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output fg_step_t                 rd_data
);

  fg_step_t mem [DEPTH];

  // NOTE: storage is deliberately left out of reset so it maps to plain RAM/flops without a reset net.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/fg_seq_ctrl.sv
// Waveform step sequencer: plays the step table into the core's sig_type/set_count/duty.
// Define FG_SEQ_SWEEP_EN to add per-step count sweeping (wr_delta applied on every tick).
module fg_seq_ctrl
  import fg_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int DWELL_W  = 16,
  parameter int TICK_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst,
  fg_seq_ctrl_if.slave bus
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  seq_state_t         state, state_next;
  logic [IW-1:0]      cur_step;
  logic [IW:0]        num_lat;
  logic [PW-1:0]      prescaler;
  logic [DWELL_W-1:0] dwell;
  signal_t            cfg_sig_type;
  logic [31:0]        cfg_set_count;
  logic [7:0]         cfg_duty;
  logic               cfg_valid;
  fg_step_t           wr_step, rd_step;
  logic               tick, expire, last_step;

  always_comb begin
    wr_step           = '0;
    wr_step.sig_type  = bus.wr_sig_type;
    wr_step.set_count = bus.wr_set_count;
    wr_step.duty      = bus.wr_duty;
    wr_step.dwell     = FG_DWELL_MAX_W'(bus.wr_dwell);
`ifdef FG_SEQ_SWEEP_EN
    wr_step.delta     = bus.wr_delta;
`endif
  end

  fg_seq_table #(.DEPTH(DEPTH)) u_table (
    .clk     (clk),
    .wr_en   (bus.wr_en),
    .wr_idx  (bus.wr_idx),
    .wr_data (wr_step),
    .rd_idx  (cur_step),
    .rd_data (rd_step)
  );

  assign tick      = (state == DWELL) && (prescaler == PW'(TICK_DIV - 1));
  // dwell is at least 1 in DWELL, so the tick that sees 1 is the one that empties it.
  assign expire    = tick && (dwell == DWELL_W'(1));
  assign last_step = ({1'b0, cur_step} == (num_lat - 1'b1));

`ifdef FG_SEQ_SWEEP_EN
  logic signed [15:0] step_delta;
  logic [31:0]        sweep_count;
  assign sweep_count = fg_sweep_count(cfg_sig_type, cfg_set_count, step_delta);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  // NOTE: every combinational output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start && !bus.stop && bus.num_steps != '0) state_next = LOAD;
      LOAD:    state_next = bus.stop ? IDLE : DWELL;
      DWELL: begin
        if (bus.stop)
          state_next = IDLE;
        else if (expire)
          state_next = (last_step && !bus.loop_en) ? DONE : LOAD;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_step      <= '0;
      num_lat       <= '0;
      prescaler     <= '0;
      dwell         <= '0;
      cfg_sig_type  <= SINE;
      cfg_set_count <= FG_RST_COUNT;
      cfg_duty      <= '0;
      cfg_valid     <= 1'b0;
`ifdef FG_SEQ_SWEEP_EN
      step_delta    <= '0;
`endif
    end else begin
      cfg_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (state_next == LOAD) begin
            cur_step <= '0;
            num_lat  <= bus.num_steps;
          end
        end
        LOAD: begin
          if (!bus.stop) begin
            cfg_sig_type  <= rd_step.sig_type;
            cfg_set_count <= fg_clamp_count(rd_step.sig_type, rd_step.set_count);
            cfg_duty      <= rd_step.duty;
            cfg_valid     <= 1'b1;
            dwell         <= (rd_step.dwell == '0) ? DWELL_W'(1) : DWELL_W'(rd_step.dwell);
            prescaler     <= '0;
`ifdef FG_SEQ_SWEEP_EN
            step_delta    <= rd_step.delta;
`endif
          end
        end
        DWELL: begin
          if (!bus.stop) begin
            prescaler <= tick ? '0 : prescaler + PW'(1);
            if (tick)
              dwell <= dwell - DWELL_W'(1);
            if (expire && state_next == LOAD)
              cur_step <= last_step ? '0 : cur_step + IW'(1);
`ifdef FG_SEQ_SWEEP_EN
            // A saturated sweep that leaves the count unchanged produces no pulse.
            if (tick && sweep_count != cfg_set_count) begin
              cfg_set_count <= sweep_count;
              cfg_valid     <= 1'b1;
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy           = (state == LOAD) || (state == DWELL);
  assign bus.done           = (state == DONE);
  assign bus.cur_step       = cur_step;
  assign bus.cfg_sig_type   = cfg_sig_type;
  assign bus.cfg_set_count  = cfg_set_count;
  assign bus.cfg_duty_cycle = cfg_duty;
  assign bus.cfg_valid      = cfg_valid;

endmodule

// File: tb/tb_fg_seq_ctrl.sv
// Scoreboard bench for fg_seq_ctrl with TICK_DIV=4; the sweep scenario runs when FG_SEQ_SWEEP_EN is defined.
module tb_fg_seq_ctrl;
  import fg_pkg::*;

  localparam int DEPTH    = 8;
  localparam int DWELL_W  = 16;
  localparam int TICK_DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cycle = 0;

  typedef struct {
    signal_t     t;
    logic [31:0] cnt;
    logic [7:0]  duty;
    int          cyc;
  } exp_t;

  exp_t q[$];

  fg_seq_ctrl_if #(.DEPTH(DEPTH), .DWELL_W(DWELL_W)) bus ();

  fg_seq_ctrl #(.DEPTH(DEPTH), .DWELL_W(DWELL_W), .TICK_DIV(TICK_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Every cfg_valid pulse must match the oldest expected configuration and its cycle.
  always @(posedge clk) begin
    #1;
    if (bus.cfg_valid === 1'b1) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL cfg_pulse: unexpected cfg_valid at cycle %0d count=%0d", cycle, bus.cfg_set_count);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (bus.cfg_sig_type !== e.t || bus.cfg_set_count !== e.cnt ||
            bus.cfg_duty_cycle !== e.duty || cycle != e.cyc) begin
          bad++;
          $display("FAIL cfg_pulse: got type=%0d cnt=%0d duty=%0d cyc=%0d, want type=%0d cnt=%0d duty=%0d cyc=%0d",
                   bus.cfg_sig_type, bus.cfg_set_count, bus.cfg_duty_cycle, cycle,
                   e.t, e.cnt, e.duty, e.cyc);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input signal_t t, input logic [31:0] cnt, input logic [7:0] duty, input int cyc);
    exp_t e;
    e.t = t; e.cnt = cnt; e.duty = duty; e.cyc = cyc;
    q.push_back(e);
  endtask

  task automatic write_entry(input int idx, input signal_t t, input logic [31:0] cnt,
                             input logic [7:0] duty, input logic [15:0] dwl, input logic signed [15:0] delta);
    bus.wr_en        = 1'b1;
    bus.wr_idx       = 3'(idx);
    bus.wr_sig_type  = t;
    bus.wr_set_count = cnt;
    bus.wr_duty      = duty;
    bus.wr_dwell     = dwl;
`ifdef FG_SEQ_SWEEP_EN
    bus.wr_delta     = delta;
`else
    if (delta != 16'sd0) $display("note: delta ignored without sweep support");
`endif
    step(1);
    bus.wr_en = 1'b0;
  endtask

  // Raises start for the next edge (edge0) and returns the cycle count before it.
  task automatic issue_start(input int n, input logic lp, output int sc);
    bus.num_steps = 4'(n);
    bus.loop_en   = lp;
    bus.start     = 1'b1;
    sc            = cycle;
    step(1);
    bus.start     = 1'b0;
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  task automatic check_drained(input string name);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL %s: %0d expected cfg pulses never seen", name, q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    int sc;
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.cur_step !== 3'd0 ||
        bus.cfg_sig_type !== SINE || bus.cfg_set_count !== 32'd999 ||
        bus.cfg_duty_cycle !== 8'd0 || bus.cfg_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: busy=%b done=%b step=%0d type=%0d cnt=%0d duty=%0d valid=%b",
               bus.busy, bus.done, bus.cur_step, bus.cfg_sig_type, bus.cfg_set_count,
               bus.cfg_duty_cycle, bus.cfg_valid);
    end
    rst = 1'b0;
    step(1);
    write_entry(0, SQUARE, 32'd1234, 8'd50, 16'd3, 16'sd0);
    issue_start(1, 1'b0, sc);
    push_exp(SQUARE, 32'd1234, 8'd50, sc + 2);
    step(4);                       // now after edge4, inside DWELL
    rst = 1'b1;
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.cfg_set_count !== 32'd999 || bus.cfg_sig_type !== SINE) begin
      bad++;
      $display("FAIL async_reset: busy=%b cnt=%0d type=%0d want busy=0 cnt=999 type=0",
               bus.busy, bus.cfg_set_count, bus.cfg_sig_type);
    end
    step(1);
    rst = 1'b0;
    step(1);
    check_drained("reset_scoreboard");
  endtask

  task automatic test_sequence();
    int sc;
    write_entry(0, SINE,   32'd1000, 8'd10, 16'd3, 16'sd0);
    write_entry(1, SQUARE, 32'd2000, 8'd20, 16'd2, 16'sd0);
    issue_start(2, 1'b0, sc);
    push_exp(SINE,   32'd1000, 8'd10, sc + 2);   // LOAD at edge1
    push_exp(SQUARE, 32'd2000, 8'd20, sc + 15);  // LOAD at edge14
    check_bit("busy_after_start", bus.busy, 1'b1);
    step(12);                                    // after edge12
    check_bit("step0_still_playing", bus.cur_step, 1'b0);
    step(1);                                     // after edge13
    check_bit("step_advanced", bus.cur_step === 3'd1, 1'b1);
    step(8);                                     // after edge21
    check_bit("no_early_done", bus.done, 1'b0);
    step(1);                                     // after edge22
    check_bit("done_pulse", bus.done, 1'b1);
    check_bit("busy_in_done", bus.busy, 1'b0);
    step(1);
    check_bit("done_one_cycle", bus.done, 1'b0);
    check_drained("sequence_scoreboard");
  endtask

  task automatic test_clamp();
    int sc;
    write_entry(0, SINE,     32'd20000,  8'd1,  16'd1, 16'sd0);
    write_entry(1, PWM,      32'd600000, 8'd77, 16'd1, 16'sd0);
    write_entry(2, TRIANGLE, 32'd9999,   8'd3,  16'd0, 16'sd0);
    issue_start(3, 1'b0, sc);
    push_exp(SINE,     32'd9999,   8'd1,  sc + 2);   // LOAD edge1
    push_exp(PWM,      32'd499999, 8'd77, sc + 7);   // LOAD edge6
    push_exp(TRIANGLE, 32'd9999,   8'd3,  sc + 12);  // LOAD edge11, dwell 0 -> 1 tick
    step(14);                                        // after edge14
    check_bit("dwell0_not_done_yet", bus.done, 1'b0);
    step(1);                                         // after edge15
    check_bit("dwell0_one_tick_done", bus.done, 1'b1);
    step(1);
    check_drained("clamp_scoreboard");
  endtask

  task automatic test_loop_stop();
    int sc;
    write_entry(0, SINE,   32'd1000, 8'd10, 16'd3, 16'sd0);
    write_entry(1, SQUARE, 32'd2000, 8'd20, 16'd2, 16'sd0);
    issue_start(2, 1'b1, sc);
    push_exp(SINE,     32'd1000, 8'd10, sc + 2);
    push_exp(SQUARE,   32'd2000, 8'd20, sc + 15);
    push_exp(TRIANGLE, 32'd4321, 8'd9,  sc + 24);    // wrapped LOAD at edge23 sees the rewrite
    step(4);                                         // after edge4: start while busy is ignored
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    step(10);                                        // after edge15, entry 1 playing
    write_entry(0, TRIANGLE, 32'd4321, 8'd9, 16'd3, 16'sd0);  // after edge16
    step(6);                                         // after edge22
    check_bit("loop_wrap_step0", bus.cur_step === 3'd0, 1'b1);
    check_bit("loop_no_done", bus.done, 1'b0);
    check_bit("loop_busy", bus.busy, 1'b1);
    step(3);                                         // after edge25
    bus.stop = 1'b1;
    step(1);                                         // after edge26
    bus.stop = 1'b0;
    check_bit("stop_busy_low", bus.busy, 1'b0);
    step(3);
    check_bit("stop_no_done", bus.done, 1'b0);
    total++;
    if (bus.cfg_sig_type !== TRIANGLE || bus.cfg_set_count !== 32'd4321 || bus.cfg_duty_cycle !== 8'd9) begin
      bad++;
      $display("FAIL stop_cfg_held: type=%0d cnt=%0d duty=%0d want 1/4321/9",
               bus.cfg_sig_type, bus.cfg_set_count, bus.cfg_duty_cycle);
    end
    check_drained("loop_scoreboard");
  endtask

  task automatic test_idle_cmds();
    int sc;
    issue_start(0, 1'b0, sc);
    check_bit("zero_steps_idle", bus.busy, 1'b0);
    step(2);
    check_bit("zero_steps_still_idle", bus.busy, 1'b0);
    bus.stop = 1'b1;
    issue_start(2, 1'b0, sc);
    bus.stop = 1'b0;
    check_bit("start_stop_idle", bus.busy, 1'b0);
    step(3);
    check_drained("idle_scoreboard");                // any pulse here is flagged by the monitor
  endtask

`ifdef FG_SEQ_SWEEP_EN
  task automatic test_sweep();
    int sc;
    write_entry(0, SINE, 32'd9950, 8'd0, 16'd3, 16'sd30);
    issue_start(1, 1'b0, sc);
    push_exp(SINE, 32'd9950, 8'd0, sc + 2);          // LOAD edge1
    push_exp(SINE, 32'd9980, 8'd0, sc + 6);          // tick edge5
    push_exp(SINE, 32'd9999, 8'd0, sc + 10);         // tick edge9, saturated
    step(13);                                        // after edge13: no-change tick, DONE
    check_bit("sweep_done", bus.done, 1'b1);
    check_bit("sweep_final_count", bus.cfg_set_count === 32'd9999, 1'b1);
    step(1);
    check_drained("sweep_scoreboard");
  endtask
`endif

  initial begin
    bus.wr_en = 1'b0; bus.wr_idx = '0; bus.wr_sig_type = SINE; bus.wr_set_count = '0;
    bus.wr_duty = '0; bus.wr_dwell = '0; bus.num_steps = '0; bus.loop_en = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0;
`ifdef FG_SEQ_SWEEP_EN
    bus.wr_delta = '0;
`endif
    step(2);
    test_reset();
    test_sequence();
    test_clamp();
    test_loop_stop();
    test_idle_cmds();
`ifdef FG_SEQ_SWEEP_EN
    test_sweep();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
